// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared state encoding and default widths for mem_initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int c_default_awidth = 5;
    localparam int c_default_dwidth = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        TURN  = 2'd3
    } state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mem_initiator
// Description : Single-command memory initiator driving a shared tri-state bus.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_initiator
    import mem_pkg::*;
#(
    parameter int AWIDTH = c_default_awidth,
    parameter int DWIDTH = c_default_dwidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    state_t            r_state;
    state_t            w_next_state;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] r_rdata;
    logic              w_accept;
    logic              w_drive_en;
    logic              w_mem_wr;
    logic              w_mem_rd;
    logic              w_rsp_valid;

    assign cmd_ready = (r_state == IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
            end
            // Bus value is captured verbatim, unknown bits included
            if (r_state == READ) begin
                r_rdata <= mem_data;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mem_wr     = 1'b0;
        w_mem_rd     = 1'b0;
        w_drive_en   = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = cmd_we ? WRITE : READ;
                end
            end
            WRITE: begin
                w_mem_wr     = 1'b1;
                w_drive_en   = 1'b1;
                w_next_state = IDLE;
            end
            READ: begin
                w_mem_rd     = 1'b1;
                w_next_state = TURN;
            end
            TURN: begin
                w_rsp_valid  = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign mem_wr    = w_mem_wr;
    assign mem_rd    = w_mem_rd;
    assign mem_addr  = r_addr;
    assign rsp_valid = w_rsp_valid;
    assign rsp_rdata = r_rdata;

    // Only WRITE drives the bus, so a read followed by a write cannot collide
    assign mem_data = w_drive_en ? r_wdata : {DWIDTH{1'bz}};

endmodule : mem_initiator
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_initiator
// Description : Directed self-checking bench for mem_initiator with a memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_initiator;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          mem_wr;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    tri1  [DW-1:0] mem_data;

    logic [DW-1:0] mem [32];
    logic [DW-1:0] mem_q;

    int checks = 0;
    int errors = 0;

    mem_initiator #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: released bus reads as all-ones through the pull-up
    assign mem_q    = mem[mem_addr];
    assign mem_data = mem_rd ? mem_q : {DW{1'bz}};

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_data;
    end

    task automatic test_reset;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (cmd_ready !== 1'b0 || mem_wr !== 1'b0 || mem_rd !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl cyc=%0d: ready=%b wr=%b rd=%b rsp_valid=%b, required all 0",
                         c, cmd_ready, mem_wr, mem_rd, rsp_valid);
            end
            checks++;
            if (mem_data !== 8'hFF) begin
                errors++;
                $display("FAIL reset_bus cyc=%0d: mem_data=%h, required released (ff via pull-up)", c, mem_data);
            end
        end
        checks++;
        if (mem_addr !== 5'h00 || rsp_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: mem_addr=%h rsp_rdata=%h, required 00 00", mem_addr, rsp_rdata);
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: cmd_ready=%b, required 1", cmd_ready);
        end
        checks++;
        if (mem[31] !== 8'hA5) begin
            errors++;
            $display("FAIL reset_no_access: mem[1f]=%h, required a5", mem[31]);
        end
    endtask

    task automatic test_single_write;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 5'h1F; cmd_wdata = 8'h00;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 5'h1F || mem_data !== 8'h00 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_cycle: wr=%b rd=%b addr=%h data=%h ready=%b, required 1 0 1f 00 0",
                     mem_wr, mem_rd, mem_addr, mem_data, cmd_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_wr !== 1'b0 || cmd_ready !== 1'b1 || mem_data !== 8'hFF) begin
            errors++;
            $display("FAIL write_done: wr=%b ready=%b data=%h, required 0 1 ff", mem_wr, cmd_ready, mem_data);
        end
    endtask

    task automatic test_single_read;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 5'h1F; cmd_wdata = 8'h77;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 5'h1F || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL read_cycle: rd=%b wr=%b addr=%h rsp_valid=%b ready=%b, required 1 0 1f 0 0",
                     mem_rd, mem_wr, mem_addr, rsp_valid, cmd_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00 || mem_rd !== 1'b0 || mem_data !== 8'hFF || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL read_turn: rsp_valid=%b rdata=%h rd=%b bus=%h ready=%b, required 1 00 0 ff 0",
                     rsp_valid, rsp_rdata, mem_rd, mem_data, cmd_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_rdata !== 8'h00) begin
            errors++;
            $display("FAIL read_done: rsp_valid=%b ready=%b rdata=%h, required 0 1 00", rsp_valid, cmd_ready, rsp_rdata);
        end
    endtask

    task automatic wait_ready(inout int cyc, input string tag);
        int w;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 8) begin
            @(posedge clk); #1;
            cyc++;
            w++;
        end
        if (cmd_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: cmd_ready=%b after %0d cycles, required 1", tag, cmd_ready, w);
        end
    endtask

    task automatic test_fill_readback;
        int cyc;
        cyc = 0;
        for (int i = 0; i < 31; i++) begin
            wait_ready(cyc, "fill_wr");
            cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 5'(31 - i); cmd_wdata = 8'(i);
            @(posedge clk); #1;
            cyc++;
            checks++;
            if (mem_wr !== 1'b1 || mem_addr !== 5'(31 - i) || mem_data !== 8'(i)) begin
                errors++;
                $display("FAIL fill_write i=%0d: wr=%b addr=%h data=%h, required 1 %h %h",
                         i, mem_wr, mem_addr, mem_data, 5'(31 - i), 8'(i));
            end
        end
        wait_ready(cyc, "fill_wr");
        checks++;
        if (cyc != 62) begin
            errors++;
            $display("FAIL fill_write_cycles: took %0d, required 62", cyc);
        end
        cyc = 0;
        for (int i = 0; i < 31; i++) begin
            wait_ready(cyc, "fill_rd");
            cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 5'(31 - i); cmd_wdata = 8'hEE;
            @(posedge clk); #1;
            cyc++;
            @(posedge clk); #1;
            cyc++;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 8'(i)) begin
                errors++;
                $display("FAIL fill_read i=%0d: rsp_valid=%b rdata=%h, required 1 %h", i, rsp_valid, rsp_rdata, 8'(i));
            end
        end
        wait_ready(cyc, "fill_rd");
        cmd_valid = 1'b0;
        checks++;
        if (cyc != 93) begin
            errors++;
            $display("FAIL fill_read_cycles: took %0d, required 93", cyc);
        end
    endtask

    task automatic test_turnaround;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 5'h03; cmd_wdata = 8'h99;
        @(posedge clk); #1;
        cmd_we = 1'b1; cmd_addr = 5'h04; cmd_wdata = 8'h55;
        checks++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_data !== 8'h1C) begin
            errors++;
            $display("FAIL turn_read: rd=%b wr=%b bus=%h, required 1 0 1c", mem_rd, mem_wr, mem_data);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h1C || mem_wr !== 1'b0 || mem_data !== 8'hFF) begin
            errors++;
            $display("FAIL turn_turn: rsp_valid=%b rdata=%h wr=%b bus=%h, required 1 1c 0 ff",
                     rsp_valid, rsp_rdata, mem_wr, mem_data);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || mem_wr !== 1'b0 || mem_data !== 8'hFF) begin
            errors++;
            $display("FAIL turn_idle: ready=%b wr=%b bus=%h, required 1 0 ff", cmd_ready, mem_wr, mem_data);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (mem_wr !== 1'b1 || mem_addr !== 5'h04 || mem_data !== 8'h55) begin
            errors++;
            $display("FAIL turn_write: wr=%b addr=%h bus=%h, required 1 04 55", mem_wr, mem_addr, mem_data);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_wr !== 1'b0 || mem_data !== 8'hFF || mem[4] !== 8'h55) begin
            errors++;
            $display("FAIL turn_after: wr=%b bus=%h mem[4]=%h, required 0 ff 55", mem_wr, mem_data, mem[4]);
        end
    endtask

    task automatic test_abort;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 5'h02; cmd_wdata = 8'h00;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (mem_rd !== 1'b1) begin
            errors++;
            $display("FAIL abort_read_start: rd=%b, required 1", mem_rd);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem_rd !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || mem_addr !== 5'h00) begin
            errors++;
            $display("FAIL abort_reset: rd=%b rsp_valid=%b rdata=%h addr=%h, required 0 0 00 00",
                     mem_rd, rsp_valid, rsp_rdata, mem_addr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: ready=%b, required 1", cmd_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b0 || mem_rd !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_rsp cyc=%0d: rsp_valid=%b rd=%b, required 0 0", c, rsp_valid, mem_rd);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 32; a++) mem[a] = 8'hA5;
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 5'h1F;
        cmd_wdata = 8'hAA;
        test_reset();
        test_single_write();
        test_single_read();
        test_fill_readback();
        test_turnaround();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_initiator
`default_nettype wire

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL take parameter AWIDTH, default 5, the memory address width.
REQ-003 The block SHALL take parameter DWIDTH, default 8, the memory data width.
REQ-004 Port clk SHALL be: input, 1 bit, rising-edge clock.
REQ-005 Port rst SHALL be: input, 1 bit, synchronous active-high reset.
REQ-006 Port cmd_valid SHALL be: input, 1 bit, client command present.
REQ-007 Port cmd_ready SHALL be: output, 1 bit, block accepts a command this cycle.
REQ-008 Port cmd_we SHALL be: input, 1 bit, 1 = write, 0 = read.
REQ-009 Port cmd_addr SHALL be: input, AWIDTH bits, target address.
REQ-010 Port cmd_wdata SHALL be: input, DWIDTH bits, write data.
REQ-011 Port rsp_valid SHALL be: output, 1 bit, one-cycle read-data strobe.
REQ-012 Port rsp_rdata SHALL be: output, DWIDTH bits, captured read data.
REQ-013 Port mem_wr SHALL be: output, 1 bit, memory write enable.
REQ-014 Port mem_rd SHALL be: output, 1 bit, memory read enable.
REQ-015 Port mem_addr SHALL be: output, AWIDTH bits, memory address.
REQ-016 Port mem_data SHALL be: inout, DWIDTH bits, shared tri-state data bus.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, WRITE, READ and TURN.
REQ-018 cmd_ready SHALL be 1 only when state is IDLE and rst is 0.
REQ-019 A command SHALL be accepted only on a rising edge where cmd_valid and cmd_ready are both 1; cmd_we, cmd_addr and cmd_wdata SHALL be registered at that edge.
REQ-020 IDLE SHALL go to WRITE on an accepted write, to READ on an accepted read, and otherwise stay in IDLE.
REQ-021 WRITE SHALL last exactly one cycle with mem_wr=1, mem_rd=0, mem_addr=registered address and mem_data driven with registered data, then return to IDLE.
REQ-022 READ SHALL last exactly one cycle with mem_rd=1, mem_wr=0, mem_addr=registered address and mem_data released to Z.
REQ-023 At the end of the READ cycle, mem_data SHALL be sampled into rsp_rdata as-is, including any X or Z bits; the state SHALL then go to TURN.
REQ-024 TURN SHALL last one cycle with rsp_valid=1, mem_wr=0, mem_rd=0 and mem_data at Z, then go to IDLE.
REQ-025 rsp_valid SHALL be asserted only in TURN, for exactly one cycle per read.
REQ-026 rsp_rdata SHALL hold its value until the next read capture.
REQ-027 mem_data SHALL be driven only in WRITE and SHALL be Z in every other state, so no bus contention is possible, including on a write that immediately follows a read.
REQ-028 mem_wr, mem_rd, mem_addr and the data drive enable SHALL be decoded from registered state only, with no combinational path from any cmd_* input.
REQ-029 Latency SHALL be: write, acceptance edge to mem_wr=1 is 1 cycle, with cmd_ready high again after 2 cycles; read, acceptance to rsp_valid is 2 cycles, with cmd_ready high again after 3 cycles.
REQ-030 Addresses SHALL be passed through unmodified; every address from 0 to 2^AWIDTH-1 is legal, and there is no wrap logic.
REQ-031 While cmd_ready=0, cmd_* inputs SHALL be ignored, and a command held valid SHALL be accepted on the next IDLE cycle.

Reset
REQ-032 On any rising edge with rst=1, state SHALL go to IDLE and the following SHALL become 0: mem_wr, mem_rd, mem_addr, rsp_valid and rsp_rdata; mem_data SHALL become Z.
REQ-033 A reset asserted during WRITE or READ SHALL abort that access with no later response, and rsp_valid SHALL never assert for the aborted read.
REQ-034 No command SHALL be accepted on a cycle where rst=1.

Structure
REQ-035 Package mem_pkg SHALL hold the state enumeration and the default AWIDTH/DWIDTH constants.
REQ-036 There SHALL be no sub-module; the tri-state driver SHALL be a single continuous assignment inside mem_initiator.

Verification
REQ-037 Reset scenario: rst=1 for 2 cycles with cmd_valid=1 -> cmd_ready=0, mem_wr=mem_rd=0, mem_data=Z, and no memory access.
REQ-038 Single-write scenario: write addr 5'h1F, data 8'h00 -> mem_wr=1 for exactly 1 cycle with mem_addr=1F and mem_data=00, and cmd_ready=1 two cycles after acceptance.
REQ-039 Single-read scenario: read addr 5'h1F after that write -> rsp_valid=1 for 1 cycle, 2 cycles after acceptance, with rsp_rdata=8'h00.
REQ-040 Fill/readback scenario: with cmd_valid held high, write addresses 1F down to 01 with data 00 to 1E, then read them back in the same order -> every rsp_rdata matches, writes complete in 62 cycles, and reads complete in 93 cycles.
REQ-041 Turnaround scenario: a read immediately followed by a write -> mem_data is Z during READ and TURN, driven only in the WRITE cycle, and never driven by both sides at once.
REQ-042 Abort scenario: rst=1 during the READ cycle -> mem_rd=0 on the next cycle, rsp_valid stays 0, and state is IDLE.
